// File: rtl/vec_stream_feeder_if.sv
// Handshake bundle between the vector feeder, its operand memories, the MAC and the host.
interface vec_stream_feeder_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic              stall;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_rdata_a;
   logic [31:0]       mem_rdata_b;
   logic              vec_valid;
   logic [31:0]       vec_a;
   logic [31:0]       vec_b;
   logic              result_valid;
   logic [31:0]       result_sum;
   logic              busy;
   logic              done;
   logic [31:0]       sum_o;
   logic              err;

   modport master (
      input  start, stall, mem_rdata_a, mem_rdata_b, result_valid, result_sum,
      output mem_en, mem_addr, vec_valid, vec_a, vec_b, busy, done, sum_o, err
   );

   modport slave (
      output start, stall, mem_rdata_a, mem_rdata_b, result_valid, result_sum,
      input  mem_en, mem_addr, vec_valid, vec_a, vec_b, busy, done, sum_o, err
   );
endinterface

// File: rtl/vec_stream_feeder.sv
// Streams packed int8 operand pairs from two sync memories to the vector MAC and latches its sum.
// Optional drain watchdog enabled by defining FEEDER_TIMEOUT_EN.
module vec_stream_feeder #(
   parameter int ELEMS   = 1000,
   parameter int LANES   = 1,
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 4096
) (
   input logic                 clk,
   input logic                 rst,
   vec_stream_feeder_if.master bus
);
   localparam int              BEATS = (ELEMS + LANES - 1) / LANES;
   localparam int              REM   = ELEMS % LANES;
   localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(BEATS - 1);

   if (LANES != 1 && LANES != 4) begin : g_chk_lanes
      $error("vec_stream_feeder: LANES must be 1 or 4");
   end
   if ((64'd1 << ADDR_W) < 64'(BEATS)) begin : g_chk_addr
      $error("vec_stream_feeder: ADDR_W too small for BEATS");
   end
   if (TIMEOUT < 1) begin : g_chk_tmo
      $error("vec_stream_feeder: TIMEOUT must be positive");
   end

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_t;

   state_t          state, state_nx;
   logic [ADDR_W:0] addr, beat_cnt;
   logic            vld, issue, last_beat, accept, tmo_hit;
   logic [31:0]     keep, sum_q;

   assign accept    = (state == IDLE) && bus.start;
   assign issue     = (state == STREAM) && !bus.stall;
   assign last_beat = vld && (beat_cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = STREAM;
         STREAM:  if (issue && addr == LAST) state_nx = DRAIN;
         DRAIN:   if (bus.result_valid || tmo_hit) state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Returned words arrive one cycle after the read, so vld tracks issue with one stage of delay.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr     <= '0;
         beat_cnt <= '0;
         vld      <= 1'b0;
         sum_q    <= '0;
      end else begin
         vld <= issue;
         if (accept) begin
            addr     <= '0;
            beat_cnt <= '0;
            sum_q    <= '0;
         end else begin
            if (issue) addr <= addr + 1'b1;
            if (vld)   beat_cnt <= beat_cnt + 1'b1;
            if (state == DRAIN && bus.result_valid) sum_q <= bus.result_sum;
         end
      end
   end

   // Lanes past LANES never carry data; tail lanes of a short final beat are zeroed.
   for (genvar k = 0; k < 4; k++) begin : g_lane
      localparam bit ON   = (k < LANES);
      localparam bit TAIL = (REM != 0) && (k >= REM);
      assign keep[8*k +: 8] = {8{vld && ON && !(TAIL && last_beat)}};
   end

`ifdef FEEDER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] tcnt;
   logic          err_q;

   assign tmo_hit = (state == DRAIN) && (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state == DRAIN && state_nx == DRAIN) tcnt <= tcnt + 1'b1;
         else                                     tcnt <= '0;
         if (accept)                                err_q <= 1'b0;
         else if (tmo_hit && !bus.result_valid)     err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   assign tmo_hit = 1'b0;
   assign bus.err = 1'b0;
`endif

   assign bus.mem_en    = issue;
   assign bus.mem_addr  = addr[ADDR_W-1:0];
   assign bus.vec_valid = vld;
   assign bus.vec_a     = bus.mem_rdata_a & keep;
   assign bus.vec_b     = bus.mem_rdata_b & keep;
   assign bus.busy      = (state == STREAM) || (state == DRAIN);
   assign bus.done      = (state == FIN);
   assign bus.sum_o     = sum_q;
endmodule

// File: tb/tb_vec_stream_feeder.sv
// Two feeders (LANES=1/ELEMS=8 and LANES=4/ELEMS=6) driven side by side against a transaction-level model.
module tb_vec_stream_feeder;
   localparam int AW  = 10;
   localparam int E0  = 8;
   localparam int L0  = 1;
   localparam int E1  = 6;
   localparam int L1  = 4;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]    start, stall, rv;
   logic [31:0]   rsum [2];
   logic [31:0]   rda [2], rdb [2];
   logic [1:0]    mem_en, vv, busy, done, err;
   logic [AW-1:0] addr [2];
   logic [31:0]   va [2], vb [2], sum [2];

   vec_stream_feeder_if #(.ADDR_W(AW)) b0 ();
   vec_stream_feeder_if #(.ADDR_W(AW)) b1 ();

   vec_stream_feeder #(.ELEMS(E0), .LANES(L0), .ADDR_W(AW), .TIMEOUT(TMO)) u0 (.clk(clk), .rst(rst), .bus(b0));
   vec_stream_feeder #(.ELEMS(E1), .LANES(L1), .ADDR_W(AW), .TIMEOUT(TMO)) u1 (.clk(clk), .rst(rst), .bus(b1));

   assign b0.start = start[0];        assign b1.start = start[1];
   assign b0.stall = stall[0];        assign b1.stall = stall[1];
   assign b0.mem_rdata_a = rda[0];    assign b1.mem_rdata_a = rda[1];
   assign b0.mem_rdata_b = rdb[0];    assign b1.mem_rdata_b = rdb[1];
   assign b0.result_valid = rv[0];    assign b1.result_valid = rv[1];
   assign b0.result_sum = rsum[0];    assign b1.result_sum = rsum[1];
   assign mem_en = {b1.mem_en, b0.mem_en};
   assign vv     = {b1.vec_valid, b0.vec_valid};
   assign busy   = {b1.busy, b0.busy};
   assign done   = {b1.done, b0.done};
   assign err    = {b1.err, b0.err};
   assign addr[0] = b0.mem_addr;      assign addr[1] = b1.mem_addr;
   assign va[0] = b0.vec_a;           assign va[1] = b1.vec_a;
   assign vb[0] = b0.vec_b;           assign vb[1] = b1.vec_b;
   assign sum[0] = b0.sum_o;          assign sum[1] = b1.sum_o;

   // Synchronous operand memories
   logic [31:0] ma [2][16];
   logic [31:0] mb [2][16];
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++)
         if (mem_en[d]) begin
            rda[d] <= ma[d][addr[d][3:0]];
            rdb[d] <= mb[d][addr[d][3:0]];
         end
   end

   int errs = 0, checks = 0, cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic int elems(input int d); return (d == 0) ? E0 : E1; endfunction
   function automatic int lanes(input int d); return (d == 0) ? L0 : L1; endfunction
   function automatic int beats(input int d); return (elems(d) + lanes(d) - 1) / lanes(d); endfunction

   // Word n as the MAC should see it: only bytes holding real elements survive.
   function automatic logic [31:0] exp_word(input int d, input logic [31:0] w, input int a);
      logic [31:0] r = '0;
      for (int k = 0; k < 4; k++)
         if (k < lanes(d) && a * lanes(d) + k < elems(d)) r[8*k +: 8] = w[8*k +: 8];
      return r;
   endfunction

   function automatic int ref_mac(input int d);
      int s = 0;
      for (int e = 0; e < elems(d); e++) begin
         logic [7:0] x, y;
         x = ma[d][e / lanes(d)][8*(e % lanes(d)) +: 8];
         y = mb[d][e / lanes(d)][8*(e % lanes(d)) +: 8];
         s += int'($signed(x)) * int'($signed(y));
      end
      return s;
   endfunction

   // Model state, per DUT
   bit          active [2], streaming [2], cur_vec [2], exp_err [2], no_resp [2];
   int          issued [2], seen [2], acc [2], rv_at [2], done_at [2], cur_addr [2];
   logic [31:0] rvsum [2], exp_sum [2], ref_sum [2], last_va [2];

   function automatic void model_clear(input int d);
      active[d] = 0; streaming[d] = 0; cur_vec[d] = 0; exp_err[d] = 0;
      issued[d] = 0; seen[d] = 0; acc[d] = 0; rv_at[d] = -1; done_at[d] = -1;
      cur_addr[d] = 0; exp_sum[d] = '0;
   endfunction

   task automatic sample();
      for (int d = 0; d < 2; d++) begin
         bit me_exp, nxt_vec, acc_start;
         int nxt_addr;
         if (rst) begin
            chk("rst_ctl", {27'd0, mem_en[d], vv[d], busy[d], done[d], err[d]}, 32'd0);
            chk("rst_addr", 32'(addr[d]), 32'd0);
            chk("rst_vec", va[d] | vb[d], 32'd0);
            chk("rst_sum", sum[d], 32'd0);
            model_clear(d);
            continue;
         end
         acc_start = start[d] && !active[d];
         me_exp = streaming[d] && !stall[d];
         nxt_vec = 0;
         nxt_addr = 0;
         chk("mem_en", 32'(mem_en[d]), 32'(me_exp));
         if (me_exp) begin
            chk("mem_addr", 32'(addr[d]), 32'(issued[d]));
            nxt_vec = 1;
            nxt_addr = issued[d];
            issued[d]++;
            if (issued[d] == beats(d)) begin
               streaming[d] = 0;
               if (no_resp[d]) done_at[d] = cyc + 1 + TMO;
            end
         end
         chk("vec_valid", 32'(vv[d]), 32'(cur_vec[d]));
         if (cur_vec[d]) begin
            chk("vec_a", va[d], exp_word(d, ma[d][cur_addr[d]], cur_addr[d]));
            chk("vec_b", vb[d], exp_word(d, mb[d][cur_addr[d]], cur_addr[d]));
         end else
            chk("vec_idle", va[d] | vb[d], 32'd0);
         // MAC stand-in accumulates whatever the DUT actually delivered
         if (vv[d]) begin
            for (int k = 0; k < lanes(d); k++)
               acc[d] += int'($signed(va[d][8*k +: 8])) * int'($signed(vb[d][8*k +: 8]));
            seen[d]++;
            last_va[d] = va[d];
            if (seen[d] == beats(d) && !no_resp[d]) begin
               rv_at[d] = cyc + int'($urandom_range(1, 4));
               rvsum[d] = acc[d];
            end
         end
         if (cyc == done_at[d]) begin
            exp_sum[d] = no_resp[d] ? 32'd0 : ref_sum[d];
            exp_err[d] = no_resp[d];
         end
         chk("done", 32'(done[d]), 32'(cyc == done_at[d]));
         chk("busy", 32'(busy[d]), 32'(active[d] && cyc != done_at[d]));
         chk("sum_o", sum[d], exp_sum[d]);
         chk("err", 32'(err[d]), 32'(exp_err[d]));
         if (cyc == done_at[d]) active[d] = 0;
         if (acc_start) begin
            active[d] = 1; streaming[d] = 1; issued[d] = 0; seen[d] = 0; acc[d] = 0;
            exp_sum[d] = '0; exp_err[d] = 0; rv_at[d] = -1; done_at[d] = -1;
         end
         cur_vec[d] = nxt_vec;
         cur_addr[d] = nxt_addr;
      end
   endtask

   task automatic step(input logic [1:0] st, input logic [1:0] sl, input bit r);
      @(posedge clk);
      #1;
      cyc++;
      rst = r;
      for (int d = 0; d < 2; d++) begin
         start[d] = st[d];
         stall[d] = sl[d];
         rv[d] = 1'b0;
         rsum[d] = $urandom;
         if (cyc == rv_at[d]) begin
            rv[d] = 1'b1;
            rsum[d] = rvsum[d];
            done_at[d] = cyc + 1;
         end else if ((streaming[d] || !active[d] || cyc == done_at[d]) && $urandom_range(0, 4) == 0)
            rv[d] = 1'b1;
      end
      #1;
      sample();
   endtask

   // kind: 0 random, 1 plain, 2 stall in cycles 3-4, 3 start mid-run, 4 reset mid-run, 5 no MAC response
   task automatic run(input int kind);
      logic [1:0] st, sl;
      bit r;
      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 16; w++) begin
            ma[d][w] = $urandom;
            mb[d][w] = $urandom;
         end
      if (kind == 1) begin
         for (int i = 0; i < 8; i++) begin
            ma[0][i] = ($urandom & 32'hFFFF_FF00) | 32'(i + 1);
            mb[0][i] = ($urandom & 32'hFFFF_FF00) | 32'(i + 5);
         end
         ma[1][1] = 32'h7F7F_7F7F;
      end
      for (int d = 0; d < 2; d++) begin
         ref_sum[d] = ref_mac(d);
         no_resp[d] = (kind == 5);
      end
      for (int rel = 0; rel < 300; rel++) begin
         st = 2'b00; sl = 2'b00; r = 0;
         if (rel == 0) st = 2'b11;
         if (kind == 3 && rel == 3) st = 2'b11;
         if (kind == 2 && (rel == 3 || rel == 4)) sl = 2'b11;
         if (kind == 4 && rel == 3) r = 1;
         if (kind == 0)
            for (int d = 0; d < 2; d++) begin
               if (active[d] && $urandom_range(0, 7) == 0) st[d] = 1'b1;
               sl[d] = ($urandom_range(0, 3) == 0);
            end
         step(st, sl, r);
         if (rel > 0 && !active[0] && !active[1]) break;
      end
      chk("run_end", 32'(active[0] | active[1]), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      start = '0; stall = '0; rv = '0;
      rsum[0] = '0; rsum[1] = '0;
      for (int d = 0; d < 2; d++) model_clear(d);
      step(2'b00, 2'b00, 1);
      step(2'b00, 2'b00, 1);
      step(2'b00, 2'b00, 0);
      run(1);
      chk("dir_sum", sum[0], 32'd348);
      chk("dir_tail", last_va[1], 32'h0000_7F7F);
      run(2);
      run(3);
      run(4);
      run(1);
`ifdef FEEDER_TIMEOUT_EN
      run(5);
      chk("tmo_err", 32'(err[0]), 32'd1);
      chk("tmo_sum", sum[0], 32'd0);
`endif
      for (int i = 0; i < 30; i++) run(0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/vec_stream_feeder.md
# vec_stream_feeder

Source side of the packed int8 vector stream consumed by the vector MAC top. On a start pulse it reads operand words from two synchronous memories and drives `vec_valid`/`vec_a`/`vec_b` beat by beat. It then waits for the MAC's `result_valid` and latches `result_sum` into a status register for the host, raising a one-cycle `done`.

## Interface
- `ELEMS`, 1000: vector length in int8 elements.
- `LANES`, 1: elements per beat, 1 or 4. Must equal the MAC's `ACTIVE_LANES`.
- `ADDR_W`, 10: memory address width. Must satisfy 2^ADDR_W ≥ BEATS.
- `TIMEOUT`, 4096: drain watchdog limit in cycles. Used only with `FEEDER_TIMEOUT_EN`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to stream one vector pair.
- `stall` in 1: while high, no new memory read is issued.
- `mem_en` out 1: read enable, shared by memories A and B.
- `mem_addr` out ADDR_W: word address, shared by A and B.
- `mem_rdata_a` in 32: word from memory A, one cycle after `mem_en`.
- `mem_rdata_b` in 32: word from memory B, one cycle after `mem_en`.
- `vec_valid` out 1: beat strobe to the MAC.
- `vec_a` out 32: packed operand A (lane k = bits [8k+7:8k]).
- `vec_b` out 32: packed operand B, same packing.
- `result_valid` in 1: MAC result strobe.
- `result_sum` in 32: MAC result.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle completion pulse.
- `sum_o` out 32: latched result. Holds until the next accepted start.
- `err` out 1: watchdog expiry flag. Cleared by the next accepted start.

## Operation
- BEATS = ceil(ELEMS/LANES). Beat counter and address counter are each ADDR_W+1 bits.
- FSM states: IDLE, STREAM, DRAIN, FIN.
- IDLE → STREAM on `start`. The transition clears `mem_addr`, the issue count, `sum_o` and `err`.
- `start` is ignored in every state other than IDLE.
- STREAM: each cycle with `stall`=0 it drives `mem_en`=1 and the current `mem_addr`, then increments the address.
- STREAM → DRAIN in the cycle that issues read BEATS-1.
- `vec_valid` is `mem_en` delayed by one cycle. `vec_a`/`vec_b` are the returned words after lane masking.
- Lane masking:
  - LANES=1: bits [31:8] are forced to 0.
  - LANES=4: on the final beat, when ELEMS mod 4 ≠ 0, lanes ≥ (ELEMS mod 4) are forced to 0.
  - Masked lanes therefore add nothing to the MAC sum.
- When `vec_valid`=0, `vec_a`/`vec_b` are 0.
- DRAIN: the first `result_valid` latches `result_sum` into `sum_o` and moves the FSM to FIN.
- FIN: `done`=1 for exactly one cycle, then IDLE.
- `result_valid` is ignored in IDLE, STREAM and FIN.
- `busy` = (state ≠ IDLE) and (state ≠ FIN).

## Timing
- Reset values: state IDLE; `mem_en`, `mem_addr`, `vec_valid`, `vec_a`, `vec_b`, `busy`, `done`, `sum_o`, `err` all 0.
- Without stalls, with `start` sampled at cycle 0:
  - `mem_en` is high in cycles 1..BEATS, with `mem_addr` = n in cycle n+1.
  - `vec_valid` is high in cycles 2..BEATS+1 and carries word n in cycle n+2.
- `stall` is sampled in the cycle it is high. That cycle issues no read, and a matching `vec_valid` gap appears one cycle later.
- Beats that are already in flight are always delivered. `stall` during DRAIN has no effect.
- `result_valid` in cycle t gives `done`=1 and the new `sum_o` in cycle t+1.
- `start` in the same cycle as FIN `done` is ignored. A new `start` is accepted one cycle later.
- `rst` asserted mid-operation:
  - Returns to IDLE immediately and drops `vec_valid`/`mem_en` with no completion beat.
  - The MAC must be reset alongside.

## Configuration
- `FEEDER_TIMEOUT_EN` defined:
  - A counter runs in DRAIN.
  - If `result_valid` has not arrived after TIMEOUT cycles in DRAIN, the block sets `err`=1, leaves `sum_o`=0 and goes to FIN, so `done` still pulses.
- `FEEDER_TIMEOUT_EN` undefined:
  - DRAIN waits indefinitely.
  - `err` is tied to 0 and no counter is synthesized.

## Test plan
- LANES=1, ELEMS=4, A=[1,2,3,4], B=[5,6,7,8]:
  - `vec_a` = 0x00000001..0x00000004 in cycles 2..5.
  - The model MAC returns 70, so `sum_o`=70 with `done` one cycle after `result_valid`.
- LANES=4, ELEMS=6, memory word 1 = 0x7F7F7F7F:
  - 2 beats.
  - Second beat `vec_a`=0x00007F7F, i.e. upper lanes masked.
- LANES=1, ELEMS=8, `stall` high in cycles 3–4:
  - `mem_en` has a 2-cycle gap.
  - Exactly 8 `vec_valid` beats with addresses 0..7 in order.
- `start` pulsed in cycle 3 of an active run → ignored: `mem_addr` sequence unaffected and `done` pulses exactly once.
- `rst` in cycle 3 of a run:
  - All outputs read 0 in the following cycle.
  - A new `start` replays from `mem_addr`=0.
- With `FEEDER_TIMEOUT_EN`, TIMEOUT=16 and no `result_valid`: `done`=1, `err`=1 and `sum_o`=0 exactly 16 cycles after entering DRAIN.
